// File: rtl/reg_file_scoreboard_if.sv
// reg_file_scoreboard_if: write, read, issue and hazard signals of the decode register file.
interface reg_file_scoreboard_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  WRITE_ENABLE;
   logic [ADDR_WIDTH-1:0] WRITE_ADDRESS;
   logic [DATA_WIDTH-1:0] WRITE_DATA;
   logic [ADDR_WIDTH-1:0] DATA1_ADDRESS;
   logic [ADDR_WIDTH-1:0] DATA2_ADDRESS;
   logic [DATA_WIDTH-1:0] DATA1;
   logic [DATA_WIDTH-1:0] DATA2;
   logic                  ISSUE_ENABLE;
   logic [ADDR_WIDTH-1:0] ISSUE_ADDRESS;
   logic                  ISSUE_REJECT;
   logic                  BUSY1;
   logic                  BUSY2;
   modport master (
      output WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, DATA1_ADDRESS, DATA2_ADDRESS,
             ISSUE_ENABLE, ISSUE_ADDRESS,
      input  DATA1, DATA2, ISSUE_REJECT, BUSY1, BUSY2
   );
   modport slave (
      input  WRITE_ENABLE, WRITE_ADDRESS, WRITE_DATA, DATA1_ADDRESS, DATA2_ADDRESS,
             ISSUE_ENABLE, ISSUE_ADDRESS,
      output DATA1, DATA2, ISSUE_REJECT, BUSY1, BUSY2
   );
endinterface

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with write-through bypass and per-register
// pending-write counters for RAW hazard detection in decode.
module reg_file_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter bit ZERO_REG   = 1'b1,
   parameter int PEND_WIDTH = 2
) (
   input logic CLK,
   input logic RESET,
   reg_file_scoreboard_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};
   localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

   logic [DATA_WIDTH-1:0] reg_q [DEPTH];
   logic [DATA_WIDTH-1:0] reg_d [DEPTH];
   logic [PEND_WIDTH-1:0] pend_q [DEPTH];
   logic [PEND_WIDTH-1:0] pend_d [DEPTH];
   logic we, ie, issue_ok, reject;

   function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
      return ZERO_REG && a == '0;
   endfunction

   // Held-off while in reset so bypass, issue and busy all read as idle.
   assign we = bus.WRITE_ENABLE && RESET;
   assign ie = bus.ISSUE_ENABLE && RESET && !is_zero(bus.ISSUE_ADDRESS);

   function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
      return is_zero(a) ? '0 : (we && bus.WRITE_ADDRESS == a) ? bus.WRITE_DATA : reg_q[a];
   endfunction

   // Busy means an outstanding write remains once this cycle's writeback retires.
   function automatic logic busy(input logic [ADDR_WIDTH-1:0] a);
      return !is_zero(a) && (pend_q[a] > PEND_ONE ||
             (pend_q[a] == PEND_ONE && !(we && bus.WRITE_ADDRESS == a)));
   endfunction

   assign reject   = ie && pend_q[bus.ISSUE_ADDRESS] == PEND_MAX &&
                     !(we && bus.WRITE_ADDRESS == bus.ISSUE_ADDRESS);
   assign issue_ok = ie && !reject;

   assign bus.DATA1        = rd(bus.DATA1_ADDRESS);
   assign bus.DATA2        = rd(bus.DATA2_ADDRESS);
   assign bus.BUSY1        = busy(bus.DATA1_ADDRESS);
   assign bus.BUSY2        = busy(bus.DATA2_ADDRESS);
   assign bus.ISSUE_REJECT = reject;

   always_comb begin
      reg_d  = reg_q;
      pend_d = pend_q;
      if (we && !is_zero(bus.WRITE_ADDRESS)) reg_d[bus.WRITE_ADDRESS] = bus.WRITE_DATA;
      for (int i = 0; i < DEPTH; i++) begin
         logic inc, dec;
         inc = issue_ok && bus.ISSUE_ADDRESS == ADDR_WIDTH'(i);
         dec = we && bus.WRITE_ADDRESS == ADDR_WIDTH'(i) && pend_q[i] != '0;
         pend_d[i] = (inc && !dec) ? pend_q[i] + PEND_ONE :
                     (dec && !inc) ? pend_q[i] - PEND_ONE : pend_q[i];
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_q[i]  <= '0;
            pend_q[i] <= '0;
         end
      end else begin
         reg_q  <= reg_d;
         pend_q <= pend_d;
      end
   end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: drives a ZERO_REG=1 and a ZERO_REG=0 instance with the same
// stimulus; expected outputs are queued by the driver and checked by a monitor.
module tb_reg_file_scoreboard;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   reg_file_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus0 ();
   reg_file_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus1 ();

   reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .PEND_WIDTH(2))
      dut0 (.CLK(clk), .RESET(rst_n), .bus(bus0.slave));
   reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b0), .PEND_WIDTH(2))
      dut1 (.CLK(clk), .RESET(rst_n), .bus(bus1.slave));

   typedef struct {
      logic [31:0] d1, d2;
      logic        b1, b2, rj;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int compared = 0;
   int mismatched = 0;

   logic [31:0] mreg [2][32];
   int          mpend [2][32];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s dut%0d t=%0t: got %h want %h", name, k, $time, act, req);
      end
   endtask

   task automatic cmp(input int k, input exp_t e, input exp_t a);
      chk("DATA1", k, a.d1, e.d1);
      chk("DATA2", k, a.d2, e.d2);
      chk("BUSY1", k, 32'(a.b1), 32'(e.b1));
      chk("BUSY2", k, 32'(a.b2), 32'(e.b2));
      chk("ISSUE_REJECT", k, 32'(a.rj), 32'(e.rj));
   endtask

   // Monitor: outputs are presented every cycle and sampled on the falling edge.
   initial forever begin
      @(negedge clk);
      if (q0.size() != 0 && q1.size() != 0) begin
         cmp(0, q0.pop_front(), '{bus0.DATA1, bus0.DATA2, bus0.BUSY1, bus0.BUSY2, bus0.ISSUE_REJECT});
         cmp(1, q1.pop_front(), '{bus1.DATA1, bus1.DATA2, bus1.BUSY1, bus1.BUSY2, bus1.ISSUE_REJECT});
      end
   end

   // Reference model: a register holds its last write; the counter is the number of
   // accepted issues not yet matched by a writeback, capped at 3.
   function automatic exp_t model(input int k, input bit rn, input bit we, input int wa,
                                  input logic [31:0] wd, input int a1, input int a2,
                                  input bit ie, input int ia);
      exp_t e;
      bit z;
      int left1, left2;
      z = (k == 0);
      e = '{32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
      if (!rn) begin
         for (int i = 0; i < 32; i++) begin
            mreg[k][i] = 32'h0;
            mpend[k][i] = 0;
         end
         return e;
      end
      e.d1 = (z && a1 == 0) ? 32'h0 : (we && wa == a1) ? wd : mreg[k][a1];
      e.d2 = (z && a2 == 0) ? 32'h0 : (we && wa == a2) ? wd : mreg[k][a2];
      left1 = mpend[k][a1] - ((we && wa == a1 && mpend[k][a1] > 0) ? 1 : 0);
      left2 = mpend[k][a2] - ((we && wa == a2 && mpend[k][a2] > 0) ? 1 : 0);
      e.b1 = !(z && a1 == 0) && left1 > 0;
      e.b2 = !(z && a2 == 0) && left2 > 0;
      e.rj = ie && !(z && ia == 0) && mpend[k][ia] == 3 && !(we && wa == ia);
      if (we && !(z && wa == 0)) mreg[k][wa] = wd;
      if (we && mpend[k][wa] > 0) mpend[k][wa]--;
      if (ie && !(z && ia == 0) && !e.rj) mpend[k][ia]++;
      return e;
   endfunction

   task automatic cyc(input bit rn, input bit we, input int wa, input logic [31:0] wd,
                      input int a1, input int a2, input bit ie, input int ia);
      @(posedge clk);
      #1;
      rst_n = rn;
      bus0.WRITE_ENABLE = we;  bus1.WRITE_ENABLE = we;
      bus0.WRITE_ADDRESS = 5'(wa); bus1.WRITE_ADDRESS = 5'(wa);
      bus0.WRITE_DATA = wd;    bus1.WRITE_DATA = wd;
      bus0.DATA1_ADDRESS = 5'(a1); bus1.DATA1_ADDRESS = 5'(a1);
      bus0.DATA2_ADDRESS = 5'(a2); bus1.DATA2_ADDRESS = 5'(a2);
      bus0.ISSUE_ENABLE = ie;  bus1.ISSUE_ENABLE = ie;
      bus0.ISSUE_ADDRESS = 5'(ia); bus1.ISSUE_ADDRESS = 5'(ia);
      q0.push_back(model(0, rn, we, wa, wd, a1, a2, ie, ia));
      q1.push_back(model(1, rn, we, wa, wd, a1, a2, ie, ia));
   endtask

   initial begin
      bus0.WRITE_ENABLE = 0; bus0.ISSUE_ENABLE = 0; bus1.WRITE_ENABLE = 0; bus1.ISSUE_ENABLE = 0;
      cyc(0, 1, 5, 32'h11, 5, 0, 1, 5);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 5, 32'hDEADBEEF, 5, 0, 1, 5);
      cyc(1, 0, 0, 0, 5, 5, 0, 0);
      cyc(0, 1, 5, 32'h5, 5, 5, 1, 5);
      cyc(1, 0, 0, 0, 5, 5, 0, 0);
      cyc(1, 1, 1, 32'd10, 1, 2, 0, 0);
      cyc(1, 0, 0, 0, 1, 1, 0, 0);
      cyc(1, 1, 0, 32'h1234, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 32'h0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 3, 1, 3);
      cyc(1, 0, 0, 0, 0, 3, 1, 3);
      cyc(1, 1, 3, 32'd7, 0, 3, 0, 0);
      cyc(1, 1, 3, 32'd9, 0, 3, 0, 0);
      cyc(1, 0, 0, 0, 4, 3, 1, 4);
      cyc(1, 0, 0, 0, 4, 4, 1, 4);
      cyc(1, 0, 0, 0, 4, 4, 1, 4);
      cyc(1, 0, 0, 0, 4, 4, 1, 4);
      cyc(1, 1, 4, 32'h44, 4, 4, 1, 4);
      cyc(1, 0, 0, 0, 4, 4, 1, 4);
      cyc(1, 1, 6, 32'h66, 6, 6, 0, 0);
      cyc(1, 0, 0, 0, 6, 6, 1, 6);
      cyc(1, 0, 0, 0, 6, 0, 0, 0);
      for (int n = 0; n < 1500; n++)
         cyc($urandom_range(63) != 0, 1'($urandom), int'($urandom_range(7)), $urandom,
             int'($urandom_range(7)), int'($urandom_range(7)), $urandom_range(2) != 0,
             int'($urandom_range(7)));
      repeat (3) @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d entries left want 0", q0.size() + q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/reg_file_scoreboard.md
# reg_file_scoreboard

Parametrised successor to the pipeline register file, for the decode stage of the RV32IM pipeline. It provides one synchronous write port and two combinational read ports with write-through bypass, and an optionally hardwired zero register. It also keeps a per-register pending-write counter (scoreboard) that decode uses to detect RAW hazards against in-flight instructions.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH registers
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never pending
- PEND_WIDTH, 2, width of each pending counter; maximum count = 2**PEND_WIDTH-1

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  asynchronous, active-low reset
- WRITE_ENABLE  input  1  writeback strobe
- WRITE_ADDRESS  input  ADDR_WIDTH  writeback destination
- WRITE_DATA  input  DATA_WIDTH  writeback value
- DATA1_ADDRESS  input  ADDR_WIDTH  read port 1 address
- DATA2_ADDRESS  input  ADDR_WIDTH  read port 2 address
- DATA1  output  DATA_WIDTH  read port 1 data, combinational
- DATA2  output  DATA_WIDTH  read port 2 data, combinational
- ISSUE_ENABLE  input  1  instruction with a destination is issuing this cycle
- ISSUE_ADDRESS  input  ADDR_WIDTH  destination of the issuing instruction
- ISSUE_REJECT  output  1  issue cannot be recorded, because the counter is saturated
- BUSY1  output  1  DATA1_ADDRESS still has an outstanding write after this cycle's writeback
- BUSY2  output  1  same as BUSY1, for DATA2_ADDRESS

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH data registers, plus one PEND_WIDTH-bit counter per register.
- Write: on a rising CLK with WRITE_ENABLE=1, REG[WRITE_ADDRESS] <= WRITE_DATA.
  - With ZERO_REG=1, a write to address 0 is dropped.
- Read, per port n:
  - With ZERO_REG=1 and address 0: DATAn = 0.
  - Otherwise, with WRITE_ENABLE=1 and WRITE_ADDRESS == DATAn_ADDRESS: DATAn = WRITE_DATA (bypass).
  - Otherwise: DATAn = REG[address].
- Pending counter PEND[a], updated on the rising edge:
  - inc = ISSUE_ENABLE && ISSUE_ADDRESS==a && !ISSUE_REJECT
  - dec = WRITE_ENABLE && WRITE_ADDRESS==a && PEND[a]!=0
  - inc and not dec: +1. dec and not inc: -1. Both, or neither: unchanged.
- ISSUE_REJECT = ISSUE_ENABLE && PEND[ISSUE_ADDRESS]==max && !(WRITE_ENABLE && WRITE_ADDRESS==ISSUE_ADDRESS).
  - When a writeback to the same address occurs in the same cycle, the issue is accepted and the count stays at max.
- Writeback with PEND==0 (unscoreboarded write): the data is written and the counter stays 0. No underflow.
- BUSYn = (PEND[addr] > 1) || (PEND[addr]==1 && !(WRITE_ENABLE && WRITE_ADDRESS==addr)).
  - BUSYn does not include a same-cycle issue.
- ZERO_REG=1: issue to address 0 is ignored (no inc, ISSUE_REJECT=0), and BUSYn=0 for address 0.
- ZERO_REG=0: register 0 behaves like every other register.

## Timing
- Write and counter updates take effect at the rising CLK edge. The written value is visible through the bypass in the same cycle, and from storage from the next cycle on.
- Read latency: 0 cycles, combinational from address, write port and state.
- Issue-to-busy latency: 1 cycle. After an accepted issue at edge k, BUSY is 1 from edge k onward.
- Writeback releases BUSY in the writeback cycle itself, combinationally, when it drops the count to 0.
- Reset, while RESET=0:
  - All REG cleared to 0 and all PEND cleared to 0, immediately and asynchronously.
  - Writes and issues are ignored.
  - Outputs: DATA1=DATA2=0 (bypass suppressed), BUSY1=BUSY2=0, ISSUE_REJECT=0.
- Reset deasserted mid-pipeline: in-flight writebacks arriving afterwards write data and leave PEND at 0.
- Simultaneous issue and writeback to different addresses: independent updates.

## Test plan
- Reset clears: write 0xDEADBEEF to r5, then pulse RESET low asynchronously between edges -> DATA1 with r5 selected reads 0 immediately, BUSY1=0.
- Write/bypass: WRITE_ENABLE=1, r1 <= 10, DATA1_ADDRESS=1 before the edge -> DATA1=10 in the same cycle; after the edge, with WRITE_ENABLE=0 -> DATA1=10.
- Zero register, ZERO_REG=1: write 0x1234 to r0 and issue to r0 -> DATA1=0, BUSY1=0, ISSUE_REJECT=0. With ZERO_REG=0, the same stimulus -> DATA1=0x1234 after the edge.
- Scoreboard: issue r3 -> BUSY2=1 next cycle. Issue r3 again -> PEND=2. Writeback r3=7 -> BUSY2 stays 1 and DATA2=7. Second writeback r3=9 -> BUSY2=0 in that cycle.
- Saturation, PEND_WIDTH=2: three issues to r4 -> PEND=3. Fourth issue alone -> ISSUE_REJECT=1 and PEND stays 3. Fourth issue together with a writeback to r4 -> ISSUE_REJECT=0 and PEND stays 3.
- Underflow guard: writeback to r6 with PEND=0 -> data written, PEND stays 0. A following issue to r6 -> PEND=1 and BUSY1=1.
